conv_window_gen: RTL

//  Builds the 3x3 convolution window directly downstream of the two cascaded line

---
 rtl/conv_window_gen_if.sv | 30 +++
 rtl/conv_window_gen.sv | 114 +++++++++++
 2 files changed

// File: rtl/conv_window_gen_if.sv
// Pixel/line-FIFO stream into the window generator and window/status results out.
// The master side is the pixel source. The slave side is conv_window_gen.
interface conv_window_gen_if #(
   parameter int WID  = 8,
   parameter int ADDR = 10
);
   logic              frame_start;
   logic [ADDR-1:0]   row_length;
   logic [ADDR-1:0]   num_rows;
   logic              pix_valid;
   logic [WID-1:0]    pix_i;
   logic [WID-1:0]    line1_i;
   logic [WID-1:0]    line2_i;
   logic              fifo_shift_o;
   logic              fifo_rst_o;
   logic [9*WID-1:0]  win_o;
   logic              win_valid_o;
   logic              frame_done_o;
   logic              cfg_err_o;

   modport master (
      output frame_start, row_length, num_rows, pix_valid, pix_i, line1_i, line2_i,
      input  fifo_shift_o, fifo_rst_o, win_o, win_valid_o, frame_done_o, cfg_err_o
   );

   modport slave (
      input  frame_start, row_length, num_rows, pix_valid, pix_i, line1_i, line2_i,
      output fifo_shift_o, fifo_rst_o, win_o, win_valid_o, frame_done_o, cfg_err_o
   );
endinterface

// File: rtl/conv_window_gen.sv
// 3x3 convolution window generator placed after the two cascaded line FIFOs.
// It shifts one column {row r-2, row r-1, row r} per accepted pixel and tracks
// the row and column position. It flags in-image windows and strobes the line
// FIFOs so that their outputs stay aligned with the pixel stream.
module conv_window_gen #(
   parameter int WID  = 8,
   parameter int ADDR = 10
) (
   input  logic             clk,
   input  logic             rst,
   conv_window_gen_if.slave bus
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [ADDR-1:0] DIM_MIN = ADDR'(3);
   localparam logic [ADDR-1:0] ONE     = ADDR'(1);
   localparam logic [ADDR-1:0] TWO     = ADDR'(2);

   state_t                     state, state_nxt;
   logic [ADDR-1:0]            col_cnt, row_cnt;
   logic [ADDR-1:0]            row_len_q, num_rows_q;
   logic [2:0][2:0][WID-1:0]   win;        // win[row][col], row0/col0 oldest
   logic                       win_valid_q;
   logic                       cfg_err_q;
   logic                       acc;
   logic                       last_pix;
   logic                       col_last;

   // A new frame always wins over a pixel in the same cycle.
   assign acc      = bus.pix_valid && (state == RUN) && !bus.frame_start;
   assign col_last = (col_cnt == row_len_q - ONE);
   assign last_pix = col_last && (row_cnt == num_rows_q - ONE);

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // Next state and the strobes derived from state
   always_comb begin
      state_nxt        = state;
      bus.fifo_shift_o = acc;
      bus.fifo_rst_o   = bus.frame_start;
      bus.frame_done_o = (state == DONE);
      case (state)
         IDLE:    state_nxt = IDLE;
         RUN:     if (acc && last_pix) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (bus.frame_start) state_nxt = RUN;
   end

   // Latch the frame dimensions. Any dimension too small for a 3x3 window is clamped and flagged.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         row_len_q  <= DIM_MIN;
         num_rows_q <= DIM_MIN;
         cfg_err_q  <= 1'b0;
      end else if (bus.frame_start) begin
         row_len_q  <= (bus.row_length < DIM_MIN) ? DIM_MIN : bus.row_length;
         num_rows_q <= (bus.num_rows   < DIM_MIN) ? DIM_MIN : bus.num_rows;
         cfg_err_q  <= (bus.row_length < DIM_MIN) || (bus.num_rows < DIM_MIN);
      end
   end

   // Position counters. Each column wrap advances the row.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         col_cnt <= '0;
         row_cnt <= '0;
      end else if (bus.frame_start) begin
         col_cnt <= '0;
         row_cnt <= '0;
      end else if (acc) begin
         if (col_last) begin
            col_cnt <= '0;
            row_cnt <= row_cnt + ONE;
         end else begin
            col_cnt <= col_cnt + ONE;
         end
      end
   end

   // Window shift register. The newest column enters at col2 and the rest shift left.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         win <= '0;
      end else if (bus.frame_start) begin
         win <= '0;
      end else if (acc) begin
         for (int r = 0; r < 3; r++) begin
            win[r][0] <= win[r][1];
            win[r][1] <= win[r][2];
         end
         win[0][2] <= bus.line2_i;
         win[1][2] <= bus.line1_i;
         win[2][2] <= bus.pix_i;
      end
   end

   // A window is complete once two earlier rows and two earlier columns of this row exist.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) win_valid_q <= 1'b0;
      else      win_valid_q <= acc && (row_cnt >= TWO) && (col_cnt >= TWO);
   end

   assign bus.win_o       = win;
   assign bus.win_valid_o = win_valid_q;
   assign bus.cfg_err_o   = cfg_err_q;

endmodule
